// File: rtl/lstm_arb_pkg.sv
// Shared types and defaults for the LSTM gate-operand delay-pipe arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default pipeline depth and requester count, and the tag
// record {valid, id} that travels alongside each data word.
package lstm_arb_pkg;

    localparam int DELAY_ARB_DEFAULT_DEPTH   = 4;
    localparam int DELAY_ARB_DEFAULT_REQ     = 4;
    localparam int DELAY_ARB_DEFAULT_ID_BITS = $clog2(DELAY_ARB_DEFAULT_REQ);

    // Tag record for the default requester count. The top level builds the
    // same {valid, id} layout at its own ID width, so non-default NUM_REQ
    // builds keep the identical bit ordering.
    typedef struct packed {
        logic                                 valid;
        logic [DELAY_ARB_DEFAULT_ID_BITS-1:0] id;
    } arb_tag_t;

endpackage

// File: rtl/delay_FIFO.sv
// Fixed-latency shift pipeline: every word advances one stage per clock.
// Latency: NUM_DELAY_CYCLE cycles from data_in to data_out.
// Backpressure: none; the pipeline shifts unconditionally every cycle.
//
// Ports: clock, reset (sync, active-high, clears every stage),
//        data_in  [INPUT_BITS_NUM-1:0] word entering stage 0,
//        data_out [INPUT_BITS_NUM-1:0] word leaving the last stage.
module delay_FIFO #(
    parameter int INPUT_BITS_NUM  = 16,
    parameter int NUM_DELAY_CYCLE = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [INPUT_BITS_NUM-1:0] data_in,
    output logic [INPUT_BITS_NUM-1:0] data_out
);

    logic [INPUT_BITS_NUM-1:0] stage [NUM_DELAY_CYCLE];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DELAY_CYCLE; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= data_in;
            for (int i = 1; i < NUM_DELAY_CYCLE; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign data_out = stage[NUM_DELAY_CYCLE-1];

endmodule

// File: rtl/rr_grant.sv
// Grant select for the delay-pipe arbiter: one-hot pick among valid requesters.
// Latency: combinational grant; priority pointer updates at the accept edge.
// Backpressure: hold or reset suppresses every grant for that cycle.
//
// Build option: DELAY_ARB_RR_EN defined -> round-robin starting at rr_ptr;
//               undefined -> fixed priority, lowest index wins (no pointer,
//               so the clock port only exists in the round-robin build).
// Ports: clock (RR build only), reset, hold, req_valid[NUM_REQ],
//        grant[NUM_REQ] one-hot, grant_id[ID_BITS] index of the set bit.
module rr_grant
    import lstm_arb_pkg::*;
#(
    parameter int NUM_REQ = DELAY_ARB_DEFAULT_REQ,
    parameter int ID_BITS = $clog2(NUM_REQ)
) (
`ifdef DELAY_ARB_RR_EN
    input  logic               clock,
`endif
    input  logic               reset,
    input  logic               hold,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_BITS-1:0] grant_id
);

    logic enable;
    logic found;

    // No grant in a reset cycle: whatever would be accepted is discarded anyway.
    assign enable = !reset && !hold;

`ifdef DELAY_ARB_RR_EN
    localparam logic [ID_BITS:0]   REQ_W   = (ID_BITS+1)'(NUM_REQ);
    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS:0]   cand;

    // Scan NUM_REQ positions starting at rr_ptr; the one-bit-wider sum plus a
    // single conditional subtract gives the modulo without needing a power of two.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_BITS+1)'(k);
            if (cand >= REQ_W) begin
                cand = cand - REQ_W;
            end
            if (enable && !found && req_valid[cand[ID_BITS-1:0]]) begin
                found    = 1'b1;
                grant_id = cand[ID_BITS-1:0];
            end
        end
        if (found) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_BITS'(1);
        end
    end
`else
    // Descending scan so the last match written is the lowest index.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (enable && req_valid[i]) begin
                found    = 1'b1;
                grant_id = ID_BITS'(i);
            end
        end
        if (found) begin
            grant[grant_id] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/delay_pipe_arbiter.sv
// Shares one fixed-latency delay pipeline among NUM_REQ requesters, tagging each word with its owner.
// Latency: word accepted in cycle t leaves with resp_valid in cycle t+NUM_DELAY_CYCLE.
// Backpressure: none downstream (consumer must always take resp_valid); hold blocks grants only.
//
// Build option: DELAY_ARB_RR_EN selects round-robin grant (else fixed priority, lowest index).
// Ports: clock, reset (sync, active-high), hold, req_valid[NUM_REQ],
//        req_data[NUM_REQ*W] (requester i at [i*W +: W]), req_ready[NUM_REQ] one-hot,
//        resp_valid, resp_id[ID_BITS], resp_data[W], in_flight[CNT_BITS], busy.
module delay_pipe_arbiter
    import lstm_arb_pkg::*;
#(
    parameter int INPUT_BITS_NUM  = 16,
    parameter int NUM_DELAY_CYCLE = DELAY_ARB_DEFAULT_DEPTH,
    parameter int NUM_REQ         = DELAY_ARB_DEFAULT_REQ,
    parameter int ID_BITS         = $clog2(NUM_REQ),
    parameter int CNT_BITS        = $clog2(NUM_DELAY_CYCLE + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              hold,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*INPUT_BITS_NUM-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              resp_valid,
    output logic [ID_BITS-1:0]                resp_id,
    output logic [INPUT_BITS_NUM-1:0]         resp_data,
    output logic [CNT_BITS-1:0]               in_flight,
    output logic                              busy
);

    // Same {valid, id} layout as arb_tag_t, sized for this instance's NUM_REQ.
    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0]        grant;
    logic [ID_BITS-1:0]        grant_id;
    logic                      accept;
    logic [INPUT_BITS_NUM-1:0] pipe_in_data;
    logic [INPUT_BITS_NUM-1:0] pipe_out_data;
    tag_t                      tag_in;
    tag_t                      tag_out;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_grant (
`ifdef DELAY_ARB_RR_EN
        .clock     (clock),
`endif
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    // Non-accept cycles push zero data so bubbles reach the output as zero.
    always_comb begin
        pipe_in_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req_valid[i]) begin
                pipe_in_data = req_data[i*INPUT_BITS_NUM +: INPUT_BITS_NUM];
            end
        end
    end

    always_comb begin
        tag_in = '0;
        if (accept) begin
            tag_in.valid = 1'b1;
            tag_in.id    = grant_id;
        end
    end

    delay_FIFO #(
        .INPUT_BITS_NUM  (INPUT_BITS_NUM),
        .NUM_DELAY_CYCLE (NUM_DELAY_CYCLE)
    ) u_data_pipe (
        .clock    (clock),
        .reset    (reset),
        .data_in  (pipe_in_data),
        .data_out (pipe_out_data)
    );

    delay_FIFO #(
        .INPUT_BITS_NUM  (ID_BITS + 1),
        .NUM_DELAY_CYCLE (NUM_DELAY_CYCLE)
    ) u_tag_pipe (
        .clock    (clock),
        .reset    (reset),
        .data_in  (tag_in),
        .data_out (tag_out)
    );

    // At most NUM_DELAY_CYCLE words can be in the pipe, so the counter never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            case ({accept, tag_out.valid})
                2'b10:   in_flight <= in_flight + CNT_BITS'(1);
                2'b01:   in_flight <= in_flight - CNT_BITS'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign resp_valid = tag_out.valid;
    assign resp_id    = tag_out.id;
    assign resp_data  = pipe_out_data;
    assign busy       = (in_flight != '0);

endmodule
